hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter REG_W, default 5, register-index width, with REG_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..6; extra cycles before a load result can be forwarded to an EX consumer.
REQ-004 SHALL have parameter BR_EXTRA, default 1, range 0..1; extra cycles a branch resolved in ID waits for any pending result.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port IF_ID_Rs, input, REG_W, first source register of the instruction held in IF/ID.
REQ-008 SHALL have port IF_ID_Rt, input, REG_W, second source register of the instruction held in IF/ID.
REQ-009 SHALL have port IF_ID_usesRt, input, 1, indicating the IF/ID instruction reads Rt.
REQ-010 SHALL have port IF_ID_isBranch, input, 1, indicating the IF/ID instruction is a branch compared in ID.
REQ-011 SHALL have port IF_ID_valid, input, 1, indicating IF/ID holds a real instruction and not a bubble.
REQ-012 SHALL have port issueValid, input, 1, indicating the IF/ID instruction advances to ID/EX this cycle.
REQ-013 SHALL have port issueDest, input, REG_W, destination register of the issuing instruction.
REQ-014 SHALL have port issueRegWrite, input, 1, indicating the issuing instruction writes issueDest.
REQ-015 SHALL have port issueIsLoad, input, 1, indicating the issuing instruction is a load.
REQ-016 SHALL have port holdPC, output, 1, freezing the PC.
REQ-017 SHALL have port holdIF_ID, output, 1, freezing the IF/ID register.
REQ-018 SHALL have port muxSelector, output, 1, zeroing ID/EX control to insert a bubble.
REQ-019 SHALL have port pendingMask, output, NUM_REGS, where bit i is high when entry i is nonzero.
REQ-020 SHALL have port stallCount, output, 16, a saturating count of stall cycles.

Function
REQ-021 SHALL keep one countdown entry per register, each 3 bits wide; entry 0 SHALL be constant 0.
REQ-022 SHALL define stall = IF_ID_valid AND (hit(IF_ID_Rs) OR (IF_ID_usesRt AND hit(IF_ID_Rt))), evaluated combinationally from the current entries.
REQ-023 SHALL define hit(r) as entry[r] > BR_EXTRA when IF_ID_isBranch = 0, and as entry[r] > 0 when IF_ID_isBranch = 1.
REQ-024 SHALL drive holdPC, holdIF_ID and muxSelector all equal to stall, with no extra cycle of latency.
REQ-025 SHALL treat an issue as effective only when issueValid = 1 and stall = 0; issueValid with stall = 1 SHALL be ignored.
REQ-026 SHALL, on an effective issue with issueRegWrite = 1 and issueDest != 0, load entry[issueDest] with LOAD_LAT + BR_EXTRA for a load, or with BR_EXTRA for a non-load.
REQ-027 SHALL decrement every other nonzero entry by 1 per cycle, stall cycles included; entries SHALL never wrap below 0.
REQ-028 SHALL let a new load of an entry in REQ-026 override that entry's decrement in the same cycle.
REQ-029 SHALL derive pendingMask from the registered entries only, with no combinational path from the issue inputs.
REQ-030 SHALL increment stallCount by 1 in every cycle with stall = 1, saturating at 16'hFFFF.
REQ-031 SHALL size the resulting stall lengths as follows (LOAD_LAT=1, BR_EXTRA=1): load-use 1 cycle; ALU-to-branch 1 cycle; load-to-branch 2 cycles; ALU-to-ALU 0 cycles.
REQ-032 SHALL never produce stall from a source of register 0 or when IF_ID_valid = 0.

Reset
REQ-033 SHALL, on reset = 1 at a clock edge, clear all entries, clear stallCount, and ignore any issue in that cycle.
REQ-034 SHALL hold holdPC, holdIF_ID and muxSelector at 0 and pendingMask at 0 in the cycle after reset; reset mid-stall SHALL end the stall on the next cycle.

Verification
REQ-035 SHALL pass: load to r8 issued, then IF_ID_Rs = 8 non-branch -> stall = 1 for exactly 1 cycle, then 0; stallCount = 1.
REQ-036 SHALL pass: ALU writes r9, then beq with Rt = 9 and usesRt = 1 -> 1 stall cycle; the same sequence with load to r9 -> 2 stall cycles.
REQ-037 SHALL pass: load to r0, then consumer of r0 -> no stall; pendingMask stays 0.
REQ-038 SHALL pass: issueValid = 1 during a stall cycle with issueDest = 5 -> entry 5 unchanged and pendingMask[5] = 0.
REQ-039 SHALL pass: LOAD_LAT = 3, load to r4, then a consumer of r4 -> 3 stall cycles; reset asserted on the 2nd stall cycle -> all outputs 0 on the next cycle.
REQ-040 SHALL pass: stallCount preset via 65535 stall cycles, plus one more stall -> value holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one countdown per architectural register decides when an
// instruction in IF/ID must stall until its source operands can be forwarded.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_EXTRA = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_W-1:0]    IF_ID_Rs,
  input  logic [REG_W-1:0]    IF_ID_Rt,
  input  logic                IF_ID_usesRt,
  input  logic                IF_ID_isBranch,
  input  logic                IF_ID_valid,
  input  logic                issueValid,
  input  logic [REG_W-1:0]    issueDest,
  input  logic                issueRegWrite,
  input  logic                issueIsLoad,
  output logic                holdPC,
  output logic                holdIF_ID,
  output logic                muxSelector,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic [15:0]         stallCount
);

  localparam logic [2:0] LoadInit = 3'(LOAD_LAT + BR_EXTRA);
  localparam logic [2:0] AluInit  = 3'(BR_EXTRA);
  localparam logic [2:0] ExThresh = 3'(BR_EXTRA);

  logic [2:0]  entry_q [NUM_REGS];
  logic [2:0]  entry_d [NUM_REGS];
  logic [2:0]  rs_cnt;
  logic [2:0]  rt_cnt;
  logic        rs_hit;
  logic        rt_hit;
  logic        stall;
  logic        issue_fire;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Branches compare in ID and need the value one stage earlier than an EX consumer.
  always_comb begin
    rs_cnt = entry_q[IF_ID_Rs];
    rt_cnt = entry_q[IF_ID_Rt];
    if (IF_ID_isBranch) begin
      rs_hit = (rs_cnt != 3'd0);
      rt_hit = (rt_cnt != 3'd0);
    end else begin
      rs_hit = (rs_cnt > ExThresh);
      rt_hit = (rt_cnt > ExThresh);
    end
    stall      = IF_ID_valid && (rs_hit || (IF_ID_usesRt && rt_hit));
    issue_fire = issueValid && !stall;
  end

  assign holdPC      = stall;
  assign holdIF_ID   = stall;
  assign muxSelector = stall;

  // A fresh issue to a register overrides that register's decrement in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      entry_d[i] = entry_q[i];
      if (i == 0) begin
        entry_d[i] = 3'd0;
      end else if (issue_fire && issueRegWrite && (issueDest == REG_W'(i))) begin
        entry_d[i] = issueIsLoad ? LoadInit : AluInit;
      end else if (entry_q[i] != 3'd0) begin
        entry_d[i] = entry_q[i] - 3'd1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        entry_q[i] <= 3'd0;
      end
      stall_cnt_q <= 16'd0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        entry_q[i] <= entry_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      pendingMask[i] = (entry_q[i] != 3'd0);
    end
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (LOAD_LAT 1, 3, 6) driven by directed
// sequences whose expected stall/mask/count values are queued per cycle.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_br;
    logic       valid;
    logic       iv;
    logic [4:0] dest;
    logic       rw;
    logic       ld;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] mask;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [3];
  in_t         din       [3];
  logic        hold_pc   [3];
  logic        hold_if_id[3];
  logic        mux_sel   [3];
  logic [31:0] pend      [3];
  logic [15:0] cnt       [3];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_scoreboard #(
      .NUM_REGS (32),
      .REG_W    (5),
      .LOAD_LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 6)),
      .BR_EXTRA (1)
    ) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .IF_ID_Rs       (din[g].rs),
      .IF_ID_Rt       (din[g].rt),
      .IF_ID_usesRt   (din[g].uses_rt),
      .IF_ID_isBranch (din[g].is_br),
      .IF_ID_valid    (din[g].valid),
      .issueValid     (din[g].iv),
      .issueDest      (din[g].dest),
      .issueRegWrite  (din[g].rw),
      .issueIsLoad    (din[g].ld),
      .holdPC         (hold_pc[g]),
      .holdIF_ID      (hold_if_id[g]),
      .muxSelector    (mux_sel[g]),
      .pendingMask    (pend[g]),
      .stallCount     (cnt[g])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                             input logic br, input logic v, input logic iv,
                             input logic [4:0] dest, input logic rw, input logic ld);
    in_t t;
    t.rs = rs; t.rt = rt; t.uses_rt = ur; t.is_br = br; t.valid = v;
    t.iv = iv; t.dest = dest; t.rw = rw; t.ld = ld;
    return t;
  endfunction

  // One cycle: drive inputs after the edge, queue the expected outputs, compare at negedge.
  task automatic step(input int idx, input in_t in, input logic r, input logic es,
                      input logic [31:0] em, input logic [15:0] ec, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    din[idx] = in;
    rst[idx] = r;
    exp_q.push_back('{stall: es, mask: em, cnt: ec});
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, "_holdpc"}, 64'(hold_pc[idx]), 64'(e.stall));
    check_val({tag, "_holdifid"}, 64'(hold_if_id[idx]), 64'(e.stall));
    check_val({tag, "_mux"}, 64'(mux_sel[idx]), 64'(e.stall));
    check_val({tag, "_mask"}, 64'(pend[idx]), 64'(e.mask));
    check_val({tag, "_cnt"}, 64'(cnt[idx]), 64'(e.cnt));
  endtask

  localparam logic [31:0] B4  = 32'h0000_0010;
  localparam logic [31:0] B6  = 32'h0000_0040;
  localparam logic [31:0] B7  = 32'h0000_0080;
  localparam logic [31:0] B8  = 32'h0000_0100;
  localparam logic [31:0] B9  = 32'h0000_0200;
  localparam logic [31:0] B10 = 32'h0000_0400;
  localparam logic [31:0] B12 = 32'h0000_1000;

  task automatic run_main();
    in_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, mk(0, 0, 0, 0, 1, 1, 3, 1, 1), 1, 0, 0, 0, "rst_issue");
    step(0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0, "rst_ignored");
    step(0, mk(1, 0, 0, 0, 1, 1, 8, 1, 1), 0, 0, 0, 0, "ld_issue");
    step(0, mk(8, 0, 0, 0, 1, 1, 10, 1, 0), 0, 1, B8, 0, "ld_use_stall");
    step(0, mk(8, 0, 0, 0, 1, 1, 10, 1, 0), 0, 0, B8, 1, "ld_use_clear");
    step(0, mk(10, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0, B10, 1, "bubble");
    step(0, mk(0, 0, 0, 0, 1, 1, 9, 1, 0), 0, 0, 0, 1, "alu9_issue");
    step(0, mk(1, 9, 1, 1, 1, 1, 0, 0, 0), 0, 1, B9, 1, "alu_br_stall");
    step(0, mk(1, 9, 1, 1, 1, 1, 0, 0, 0), 0, 0, 0, 2, "alu_br_clear");
    step(0, mk(0, 0, 0, 0, 1, 1, 9, 1, 1), 0, 0, 0, 2, "ld9_issue");
    step(0, mk(1, 9, 1, 1, 1, 1, 0, 0, 0), 0, 1, B9, 2, "ld_br_stall1");
    step(0, mk(1, 9, 1, 1, 1, 1, 0, 0, 0), 0, 1, B9, 3, "ld_br_stall2");
    step(0, mk(1, 9, 1, 1, 1, 1, 0, 0, 0), 0, 0, 0, 4, "ld_br_clear");
    step(0, mk(0, 0, 0, 0, 1, 1, 9, 1, 0), 0, 0, 0, 4, "alu9_again");
    step(0, mk(1, 9, 0, 1, 1, 0, 0, 0, 0), 0, 0, B9, 4, "no_uses_rt");
    step(0, mk(0, 0, 0, 0, 1, 1, 7, 1, 0), 0, 0, 0, 4, "alu7_issue");
    step(0, mk(7, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, B7, 4, "alu_alu");
    step(0, mk(0, 0, 0, 0, 1, 1, 0, 1, 1), 0, 0, 0, 4, "ld_r0");
    step(0, mk(0, 0, 1, 1, 1, 0, 0, 0, 0), 0, 0, 0, 4, "r0_consumer");
    step(0, mk(0, 0, 0, 0, 1, 1, 6, 1, 1), 0, 0, 0, 4, "ld6_issue");
    step(0, mk(6, 0, 0, 0, 1, 1, 5, 1, 1), 0, 1, B6, 4, "stall_issue_drop");
    step(0, idle, 0, 0, B6, 5, "dest5_ignored");
    step(0, idle, 0, 0, 0, 5, "drained");
    step(0, mk(0, 0, 0, 0, 1, 1, 12, 1, 1), 0, 0, 0, 5, "ld12_a");
    step(0, mk(0, 0, 0, 0, 1, 1, 12, 1, 1), 0, 0, B12, 5, "ld12_b");
    step(0, mk(12, 0, 0, 0, 1, 0, 0, 0, 0), 0, 1, B12, 5, "override_dec");
    step(0, idle, 0, 0, B12, 6, "override_clear");
    step(0, idle, 0, 0, 0, 6, "idle_end");
  endtask

  task automatic run_lat3();
    in_t idle;
    in_t use4;
    in_t ld4;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    use4 = mk(4, 0, 0, 0, 1, 0, 0, 0, 0);
    ld4  = mk(0, 0, 0, 0, 1, 1, 4, 1, 1);
    step(1, ld4, 0, 0, 0, 0, "l3_issue");
    step(1, use4, 0, 1, B4, 0, "l3_stall1");
    step(1, use4, 1, 1, B4, 1, "l3_stall2_rst");
    step(1, use4, 0, 0, 0, 0, "l3_after_rst");
    step(1, ld4, 0, 0, 0, 0, "l3_issue2");
    step(1, use4, 0, 1, B4, 0, "l3_s1");
    step(1, use4, 0, 1, B4, 1, "l3_s2");
    step(1, use4, 0, 1, B4, 2, "l3_s3");
    step(1, use4, 0, 0, B4, 3, "l3_clear");
    step(1, idle, 0, 0, 0, 3, "l3_idle");
  endtask

  // Constant inputs make the LOAD_LAT=6 instance stall 7 of every 8 cycles:
  // the non-stalled cycle lets the load re-issue and reload the countdown with 7.
  task automatic run_sat();
    int unsigned stalls = 0;
    logic [15:0] exp_cnt;
    logic        seen = 1'b0;
    logic        done = 1'b0;
    #1;
    din[2] = mk(1, 0, 0, 1, 1, 1, 1, 1, 1);
    rst[2] = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      @(negedge clk);
      exp_cnt = (stalls > 32'd65535) ? 16'hFFFF : stalls[15:0];
      if (k == 1) check_val("sat_stall_on", 64'(hold_pc[2]), 64'd1);
      if (k == 8) check_val("sat_gap", 64'(hold_pc[2]), 64'd0);
      if (k == 9) check_val("sat_early_cnt", 64'(cnt[2]), 64'(exp_cnt));
      if (stalls == 32'd65535 && !seen) begin
        seen = 1'b1;
        check_val("sat_reach", 64'(cnt[2]), 64'(exp_cnt));
      end
      if (stalls == 32'd65540) begin
        check_val("sat_hold", 64'(cnt[2]), 64'(exp_cnt));
        done = 1'b1;
        break;
      end
      if ((k % 8) != 0) stalls++;
    end
    if (!done) check_val("sat_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      din[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    repeat (2) @(posedge clk);
    fork
      begin
        run_main();
        run_lat3();
      end
      run_sat();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
